frame_buffer_dp: RTL and testbench

Parametrised double-buffered frame store with independent writer and reader ports. The renderer writes the back bank while the display scan reads the front bank. Bank swaps are requested by the writer and take effect only at the reader's next frame boundary, which guarantees tear-free output. An optional clear engine wipes the newly exposed back bank after each swap.

---
 rtl/fb_pkg.sv | 13 +
 rtl/sdp_bram.sv | 34 +++
 rtl/frame_buffer_dp.sv | 139 +++++++++++++
 tb/tb_frame_buffer_dp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered frame store.
package fb_pkg;

  localparam int unsigned FB_DATA_W = 12;
  localparam int unsigned FB_DEPTH  = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StClear
  } fb_state_t;

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module sdp_bram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buffer_dp.sv
// Double-buffered frame store: writer fills the back bank, reader scans the front bank,
// and swaps requested by the writer land on the reader's next frame boundary.
module frame_buffer_dp
  import fb_pkg::*;
#(
  parameter int unsigned       DATA_W    = FB_DATA_W,
  parameter int unsigned       DEPTH     = FB_DEPTH,
  parameter int unsigned       ADDR_W    = $clog2(DEPTH),
  parameter bit                CLEAR_EN  = 1'b0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  input  logic              frame_start,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              front_sel
);

  localparam logic [ADDR_W:0] ClrLast = (ADDR_W + 1)'(DEPTH - 1);

  fb_state_t         state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              front_q;
  logic              swap_done_q;
  logic              r_valid_q;
  logic              rd_sel_q;
  logic              swap_exec;
  logic              rd_sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  assign swap_exec = (state_q == StPending) && frame_start;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (swap_req) begin
          state_d = StPending;
        end
      end
      StPending: begin
        if (frame_start) begin
          state_d   = CLEAR_EN ? StClear : StIdle;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        if (clr_cnt_q == ClrLast) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      r_valid_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      front_q     <= front_q ^ swap_exec;
      swap_done_q <= swap_exec;
      r_valid_q   <= r_en;
      if (r_en) begin
        rd_sel_q <= rd_sel;
      end
    end
  end

  // Clear engine borrows the back-bank write port; writer owns it only in idle.
  always_comb begin
    wr_en   = (state_q == StClear) || ((state_q == StIdle) && w_en);
    wr_addr = (state_q == StClear) ? clr_cnt_q[ADDR_W-1:0] : w_addr;
    wr_data = (state_q == StClear) ? CLEAR_VAL : w_data;
  end

  // A read coincident with an executing swap already sees the new front bank.
  assign rd_sel = front_q ^ swap_exec;

  sdp_bram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_bank_a (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en & front_q),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re   (r_en & ~rd_sel),
    .raddr(r_addr),
    .rdata(rdata_a)
  );

  sdp_bram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_bank_b (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en & ~front_q),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re   (r_en & rd_sel),
    .raddr(r_addr),
    .rdata(rdata_b)
  );

  assign r_data       = rd_sel_q ? rdata_b : rdata_a;
  assign r_valid      = r_valid_q;
  assign w_ready      = (state_q == StIdle);
  assign swap_pending = (state_q == StPending);
  assign swap_done    = swap_done_q;
  assign front_sel    = front_q;

endmodule

// File: tb/tb_frame_buffer_dp.sv
// Bench: two instances (no clear / with clear) share stimulus and are checked against
// a bank-level reference model, a directed vector table and hand-written sequences.
module tb_frame_buffer_dp;

  localparam int DEPTH = 16;
  localparam logic [11:0] CLR = 12'h00F;

  logic        clk, rst_n;
  logic        w_en, swap_req, frame_start, r_en;
  logic [3:0]  w_addr, r_addr;
  logic [11:0] w_data;
  logic        w_ready[2], swap_pending[2], swap_done[2], r_valid[2], front_sel[2];
  logic [11:0] r_data[2];

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance (k=1 has the clear engine).
  logic [11:0] m_mem[2][2][DEPTH];
  bit          m_known[2][2][DEPTH];
  bit          m_front[2], m_pend[2], m_done[2], m_rvalid[2], m_rknown[2];
  int          m_clr[2];
  logic [11:0] m_rdata[2];

  typedef struct {
    logic we; logic [3:0] wa; logic [11:0] wd; logic sr; logic fs; logic re; logic [3:0] ra;
    logic ew_ready; logic epend; logic edone; logic efront; logic ervalid; logic [11:0] erdata;
  } vec_t;
  vec_t tbl[8];

  frame_buffer_dp #(.DATA_W(12), .DEPTH(DEPTH), .CLEAR_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready[0]), .swap_req(swap_req), .swap_pending(swap_pending[0]),
    .swap_done(swap_done[0]), .frame_start(frame_start), .r_en(r_en), .r_addr(r_addr),
    .r_data(r_data[0]), .r_valid(r_valid[0]), .front_sel(front_sel[0])
  );

  frame_buffer_dp #(.DATA_W(12), .DEPTH(DEPTH), .CLEAR_EN(1'b1), .CLEAR_VAL(CLR)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready[1]), .swap_req(swap_req), .swap_pending(swap_pending[1]),
    .swap_done(swap_done[1]), .frame_start(frame_start), .r_en(r_en), .r_addr(r_addr),
    .r_data(r_data[1]), .r_valid(r_valid[1]), .front_sel(front_sel[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_front[k] = 0; m_pend[k] = 0; m_done[k] = 0; m_rvalid[k] = 0;
      m_clr[k] = 0; m_rdata[k] = '0; m_rknown[k] = 1;
    end
  endtask

  // One clock edge of the behavioural model, using the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit eff;
      bit back;
      int idx;
      eff  = m_front[k] ^ (m_pend[k] & frame_start);
      back = ~m_front[k];
      m_done[k]   = 0;
      m_rvalid[k] = r_en;
      if (r_en) begin
        m_rdata[k]  = m_mem[k][eff][r_addr];
        m_rknown[k] = m_known[k][eff][r_addr];
      end
      if (m_clr[k] > 0) begin
        idx = DEPTH - m_clr[k];
        m_mem[k][back][idx]   = CLR;
        m_known[k][back][idx] = 1;
        m_clr[k]--;
      end else if (m_pend[k]) begin
        if (frame_start) begin
          m_front[k] = ~m_front[k];
          m_pend[k]  = 0;
          m_done[k]  = 1;
          if (k == 1) m_clr[k] = DEPTH;
        end
      end else begin
        if (w_en) begin
          m_mem[k][back][w_addr]   = w_data;
          m_known[k][back][w_addr] = 1;
        end
        if (swap_req) m_pend[k] = 1;
      end
    end
  endtask

  task automatic model_compare();
    for (int k = 0; k < 2; k++) begin
      check("w_ready", k, 32'(w_ready[k]), 32'(!m_pend[k] && m_clr[k] == 0));
      check("swap_pending", k, 32'(swap_pending[k]), 32'(m_pend[k]));
      check("swap_done", k, 32'(swap_done[k]), 32'(m_done[k]));
      check("front_sel", k, 32'(front_sel[k]), 32'(m_front[k]));
      check("r_valid", k, 32'(r_valid[k]), 32'(m_rvalid[k]));
      if (m_rknown[k]) check("r_data", k, 32'(r_data[k]), 32'(m_rdata[k]));
    end
  endtask

  // Inputs change at negedge, are sampled at posedge, outputs compared at the next negedge.
  task automatic step(input logic we, input logic [3:0] wa, input logic [11:0] wd,
                      input logic sr, input logic fs, input logic re, input logic [3:0] ra);
    w_en = we; w_addr = wa; w_data = wd; swap_req = sr; frame_start = fs;
    r_en = re; r_addr = ra;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_compare();
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while (!w_ready[1] && n < 40) begin
      idle();
      n++;
    end
    check("wait_idle", 1, 32'(w_ready[1]), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_front"}, k, 32'(front_sel[k]), 32'd0);
      check({tag, "_w_ready"}, k, 32'(w_ready[k]), 32'd1);
      check({tag, "_r_valid"}, k, 32'(r_valid[k]), 32'd0);
      check({tag, "_r_data"}, k, 32'(r_data[k]), 32'd0);
      check({tag, "_pending"}, k, 32'(swap_pending[k]), 32'd0);
      check({tag, "_done"}, k, 32'(swap_done[k]), 32'd0);
    end
  endtask

  initial begin
    int n0;
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < DEPTH; a++) m_known[k][b][a] = 0;

    // Directed table for the no-clear instance, starting from reset (front bank A).
    tbl[0] = '{1'b1, 4'd3, 12'hABC, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[1] = '{1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[2] = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[3] = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'hABC};
    tbl[4] = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'hABC};
    tbl[5] = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC};
    tbl[6] = '{1'b0, 4'd0, 12'h000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'hABC};
    tbl[7] = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'hABC};

    rst_n = 1'b0;
    w_en = 0; w_addr = '0; w_data = '0; swap_req = 0; frame_start = 0; r_en = 0; r_addr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].sr, tbl[i].fs, tbl[i].re, tbl[i].ra);
      check("tbl_w_ready", i, 32'(w_ready[0]), 32'(tbl[i].ew_ready));
      check("tbl_pending", i, 32'(swap_pending[0]), 32'(tbl[i].epend));
      check("tbl_done", i, 32'(swap_done[0]), 32'(tbl[i].edone));
      check("tbl_front", i, 32'(front_sel[0]), 32'(tbl[i].efront));
      check("tbl_r_valid", i, 32'(r_valid[0]), 32'(tbl[i].ervalid));
      check("tbl_r_data", i, 32'(r_data[0]), 32'(tbl[i].erdata));
    end

    // Pending hold: 50 cycles without frame_start, a write inside the window is dropped.
    step(1'b1, 4'd5, 12'h456, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) step(1'b1, 4'd5, 12'h123, 1'b0, 1'b0, 1'b0, 4'd0);
      else idle();
      check("hold_pending", i, 32'(swap_pending[0]), 32'd1);
      check("hold_w_ready", i, 32'(w_ready[0]), 32'd0);
    end
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd5);
    check("hold_dropped_write", 0, 32'(r_data[0]), 32'h456);

    // Clear engine: w_ready low for exactly DEPTH cycles after the swap edge.
    wait_idle1();
    step(1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0);
    check("clear_swap_done", 1, 32'(swap_done[1]), 32'd1);
    n0 = 0;
    while (!w_ready[1] && n0 < 40) begin
      n0++;
      idle();
    end
    check("clear_busy_cycles", 1, 32'(n0), 32'(DEPTH));
    step(1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'(a));
      check("cleared_word", a, 32'(r_data[1]), 32'(CLR));
    end

    // Reset seven cycles into a clear, then confirm normal operation resumes.
    wait_idle1();
    step(1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midclr");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd2, 12'h2A2, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd2);
    check("post_rst_read", 0, 32'(r_data[0]), 32'h2A2);
    check("post_rst_read", 1, 32'(r_data[1]), 32'h2A2);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(1)), 4'($urandom_range(DEPTH - 1)), 12'($urandom),
           1'($urandom_range(9) == 0), 1'($urandom_range(11) == 0),
           1'($urandom_range(1)), 4'($urandom_range(DEPTH - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
